cache_writeback_controller: RTL and testbench
=============================================

// Module: cache_writeback_controller
//
// PURPOSE
//   Eviction/writeback engine on the consumer side of the cache dirty-bit store.
//   On an eviction request it reads the line's dirty bit. If the bit is set, it
//   streams every data word of the line to the memory bus, then clears the dirty bit.
//   Sits between the cache replacement logic, the dirty/data memories and the external memory port.
//
// PARAMETERS
//   ADDR_WIDTH      8   cache index width (line select); matches dirty-bit store depth 2**ADDR_WIDTH
//   TAG_WIDTH      20   tag width; TAG_WIDTH+ADDR_WIDTH+$clog2(WORDS_PER_LINE)+2 == 32
//   WORDS_PER_LINE  4   32-bit words per line, power of two, >= 2
//   DATA_WIDTH     32   word width
//
// PORTS
//   clk_i            in   1    clock, all logic on rising edge
//   rst_i            in   1    synchronous active-high reset
//   evict_i          in   1    eviction request, sampled only while evict_ready_o=1
//   evict_index_i    in   ADDR_WIDTH  index of line to evict
//   evict_tag_i      in   TAG_WIDTH   tag of line to evict
//   evict_ready_o    out  1    high only in IDLE
//   evict_done_o     out  1    one-cycle pulse: eviction finished
//   evict_wrote_o    out  1    valid with evict_done_o: 1 = line was dirty and was written back
//   dirty_read_o     out  1    dirty-bit read strobe (read/write port)
//   dirty_write_o    out  1    dirty-bit write strobe
//   dirty_address_o  out  ADDR_WIDTH  dirty-bit address (read and write)
//   dirty_o          out  1    dirty-bit write data, always 0
//   dirty_i          in   1    dirty-bit read data, valid 1 cycle after dirty_read_o
//   data_read_o      out  1    cache data read strobe
//   data_address_o   out  ADDR_WIDTH+$clog2(WORDS_PER_LINE)  {index, word}
//   data_i           in   DATA_WIDTH  cache word, valid 1 cycle after data_read_o
//   mem_valid_o      out  1    write beat valid
//   mem_address_o    out  32   {tag, index, word, 2'b00}
//   mem_data_o       out  DATA_WIDTH  write beat data
//   mem_last_o       out  1    last beat of line
//   mem_ready_i      in   1    memory accepts beat when mem_valid_o & mem_ready_i
//
// BEHAVIOUR
//   Reset: state=IDLE; all strobes, mem_valid_o, mem_last_o, evict_done_o, evict_wrote_o = 0;
//     word counter = 0; evict_ready_o = 1. Reset mid-operation aborts; the dirty bit is left set.
//   FSM, all outputs registered:
//     IDLE   : evict_i -> latch index/tag, counter=0 -> RDIRTY
//     RDIRTY : dirty_read_o=1 for exactly 1 cycle -> CHECK
//     CHECK  : dirty_i=0 -> DONE (wrote=0); dirty_i=1 -> FETCH
//     FETCH  : data_read_o=1 for 1 cycle at {index,counter} -> CAPTURE
//     CAPTURE: register data_i into mem_data_o; mem_valid_o=1 -> SEND
//     SEND   : hold valid/addr/data/last stable until mem_ready_i;
//              on handshake, last -> CLEAR, else counter++ -> FETCH
//     CLEAR  : dirty_write_o=1, dirty_o=0 for 1 cycle -> DONE
//     DONE   : evict_done_o=1, evict_wrote_o as decided, 1 cycle -> IDLE
//   mem_last_o = (counter == WORDS_PER_LINE-1) while mem_valid_o.
//   Counter wraps to 0 on entry to IDLE; it never exceeds WORDS_PER_LINE-1.
//   Port exclusivity: dirty_read_o and dirty_write_o are never high in the same cycle.
//   Requests arriving outside IDLE are ignored; the requester holds evict_i until ready.
//   Latency: clean line = 4 cycles from request to done; dirty line
//     = 5 + 3*WORDS_PER_LINE + total mem_ready_i stall cycles.
//   Back-to-back: evict_ready_o is high the cycle after the done pulse.
//
// TESTING
//   1 clean: dirty[0x12]=0, evict idx=0x12 -> done at cycle 4, wrote=0, no mem_valid_o, no dirty write
//   2 dirty: dirty[0x05]=1, tag=0xABCDE, words A0..A3, ready=1 -> 4 beats at 0xABCDE050..5C,
//     last on 4th beat only, dirty[0x05]=0, wrote=1
//   3 stall: same as 2 with mem_ready_i low 3 cycles on beat 2 -> addr/data stable, done 3 cycles later
//   4 ignore: evict_i pulsed mid-writeback -> no effect; second request accepted after done
//   5 reset: rst_i during SEND beat 1 -> outputs 0 next cycle, IDLE, dirty bit still 1
//   6 b2b: dirty idx 0x00 then clean idx 0xFF -> correct per-request done/wrote, no overlap on dirty port

Source files
------------

// File: rtl/cache_writeback_controller.sv
// Eviction/writeback engine: reads a line's dirty bit, streams the line's words to memory
// when the bit is set, then clears the bit. Every output comes straight from a flop.
module cache_writeback_controller #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TAG_WIDTH      = 20,
  parameter int WORDS_PER_LINE = 4,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         evict_i,
  input  logic [ADDR_WIDTH-1:0]                        evict_index_i,
  input  logic [TAG_WIDTH-1:0]                         evict_tag_i,
  output logic                                         evict_ready_o,
  output logic                                         evict_done_o,
  output logic                                         evict_wrote_o,
  output logic                                         dirty_read_o,
  output logic                                         dirty_write_o,
  output logic [ADDR_WIDTH-1:0]                        dirty_address_o,
  output logic                                         dirty_o,
  input  logic                                         dirty_i,
  output logic                                         data_read_o,
  output logic [ADDR_WIDTH+$clog2(WORDS_PER_LINE)-1:0] data_address_o,
  input  logic [DATA_WIDTH-1:0]                        data_i,
  output logic                                         mem_valid_o,
  output logic [31:0]                                  mem_address_o,
  output logic [DATA_WIDTH-1:0]                        mem_data_o,
  output logic                                         mem_last_o,
  input  logic                                         mem_ready_i
);

  localparam int CNT_W = $clog2(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDIRTY,
    S_CHECK,
    S_FETCH,
    S_CAPTURE,
    S_SEND,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   index_q, index_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    wrote_q, wrote_d;
  logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    wrote_out_q, wrote_out_d;
  logic                    dirty_read_q, dirty_read_d;
  logic                    dirty_write_q, dirty_write_d;
  logic                    data_read_q, data_read_d;
  logic                    mem_valid_q, mem_valid_d;
  logic                    mem_last_q, mem_last_d;

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    wrote_d    = wrote_q;
    mem_data_d = mem_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (evict_i) begin
          index_d = evict_index_i;
          tag_d   = evict_tag_i;
          cnt_d   = '0;
          wrote_d = 1'b0;
          state_d = S_RDIRTY;
        end
      end
      S_RDIRTY:  state_d = S_CHECK;
      S_CHECK: begin
        if (dirty_i) begin
          wrote_d = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_DONE;
        end
      end
      S_FETCH:   state_d = S_CAPTURE;
      S_CAPTURE: begin
        mem_data_d = data_i;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (mem_ready_i) begin
          if (cnt_q == LAST_WORD) begin
            state_d = S_CLEAR;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_CLEAR:   state_d = S_DONE;
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase

    // Output flops are loaded from the decode of the next state so each
    // strobe lines up exactly with the state it belongs to.
    ready_d       = (state_d == S_IDLE);
    dirty_read_d  = (state_d == S_RDIRTY);
    dirty_write_d = (state_d == S_CLEAR);
    data_read_d   = (state_d == S_FETCH);
    mem_valid_d   = (state_d == S_SEND);
    mem_last_d    = (state_d == S_SEND) && (cnt_d == LAST_WORD);
    done_d        = (state_d == S_DONE);
    wrote_out_d   = (state_d == S_DONE) && wrote_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      index_q       <= '0;
      tag_q         <= '0;
      cnt_q         <= '0;
      wrote_q       <= 1'b0;
      mem_data_q    <= '0;
      ready_q       <= 1'b1;
      done_q        <= 1'b0;
      wrote_out_q   <= 1'b0;
      dirty_read_q  <= 1'b0;
      dirty_write_q <= 1'b0;
      data_read_q   <= 1'b0;
      mem_valid_q   <= 1'b0;
      mem_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      tag_q         <= tag_d;
      cnt_q         <= cnt_d;
      wrote_q       <= wrote_d;
      mem_data_q    <= mem_data_d;
      ready_q       <= ready_d;
      done_q        <= done_d;
      wrote_out_q   <= wrote_out_d;
      dirty_read_q  <= dirty_read_d;
      dirty_write_q <= dirty_write_d;
      data_read_q   <= data_read_d;
      mem_valid_q   <= mem_valid_d;
      mem_last_q    <= mem_last_d;
    end
  end

  assign evict_ready_o   = ready_q;
  assign evict_done_o    = done_q;
  assign evict_wrote_o   = wrote_out_q;
  assign dirty_read_o    = dirty_read_q;
  assign dirty_write_o   = dirty_write_q;
  assign dirty_address_o = index_q;
  assign dirty_o         = 1'b0;
  assign data_read_o     = data_read_q;
  assign data_address_o  = {index_q, cnt_q};
  assign mem_valid_o     = mem_valid_q;
  assign mem_address_o   = {tag_q, index_q, cnt_q, 2'b00};
  assign mem_data_o      = mem_data_q;
  assign mem_last_o      = mem_last_q;

endmodule

// File: tb/tb_cache_writeback_controller.sv
// Directed bench for cache_writeback_controller: dirty/data memory models plus a
// beat scoreboard filled by the stimulus and drained by a negedge monitor.
module tb_cache_writeback_controller;

  logic        clk;
  logic        rst_i;
  logic        evict_i;
  logic [7:0]  evict_index_i;
  logic [19:0] evict_tag_i;
  logic        evict_ready_o, evict_done_o, evict_wrote_o;
  logic        dirty_read_o, dirty_write_o, dirty_o, dirty_i;
  logic [7:0]  dirty_address_o;
  logic        data_read_o;
  logic [9:0]  data_address_o;
  logic [31:0] data_i;
  logic        mem_valid_o, mem_last_o, mem_ready_i;
  logic [31:0] mem_address_o, mem_data_o;

  cache_writeback_controller #(
    .ADDR_WIDTH(8), .TAG_WIDTH(20), .WORDS_PER_LINE(4), .DATA_WIDTH(32)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .evict_i(evict_i), .evict_index_i(evict_index_i), .evict_tag_i(evict_tag_i),
    .evict_ready_o(evict_ready_o), .evict_done_o(evict_done_o), .evict_wrote_o(evict_wrote_o),
    .dirty_read_o(dirty_read_o), .dirty_write_o(dirty_write_o),
    .dirty_address_o(dirty_address_o), .dirty_o(dirty_o), .dirty_i(dirty_i),
    .data_read_o(data_read_o), .data_address_o(data_address_o), .data_i(data_i),
    .mem_valid_o(mem_valid_o), .mem_address_o(mem_address_o), .mem_data_o(mem_data_o),
    .mem_last_o(mem_last_o), .mem_ready_i(mem_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; logic last; } beat_t;
  typedef struct { logic wrote; int unsigned cyc; } done_t;

  beat_t       sb[$];
  done_t       done_q[$];
  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned cyc = 0;
  int unsigned beats = 0;
  int unsigned dwrites = 0;
  int unsigned stall_checks = 0;

  bit          dirty_mem[256];
  logic [31:0] data_mem[1024];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic        pl_val;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Dirty-bit store and data store; read data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (pl_en) dirty_mem[pl_addr] <= pl_val;
    if (dirty_write_o) dirty_mem[dirty_address_o] <= dirty_o;
    dirty_i <= dirty_read_o ? dirty_mem[dirty_address_o] : 1'b0;
    data_i  <= data_read_o ? data_mem[data_address_o] : $urandom;
  end

  bit          hold_valid = 1'b0;
  logic [31:0] hold_addr, hold_data;
  logic        hold_last;

  always @(negedge clk) begin
    if (rst_i === 1'b1) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) begin
        stall_checks++;
        chk("stall_valid", mem_valid_o, 1'b1);
        chk("stall_addr", mem_address_o, hold_addr);
        chk("stall_data", mem_data_o, hold_data);
        chk("stall_last", mem_last_o, hold_last);
      end
      hold_valid = (mem_valid_o && !mem_ready_i) === 1'b1;
      hold_addr  = mem_address_o;
      hold_data  = mem_data_o;
      hold_last  = mem_last_o;
      if ((mem_valid_o && mem_ready_i) === 1'b1) begin
        beats++;
        chk("beat_expected", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_addr", mem_address_o, e.addr);
          chk("beat_data", mem_data_o, e.data);
          chk("beat_last", mem_last_o, e.last);
        end
      end
      if ((dirty_read_o || dirty_write_o) === 1'b1)
        chk("dirty_port_excl", dirty_read_o && dirty_write_o, 1'b0);
      if (dirty_write_o === 1'b1) dwrites++;
      if (evict_done_o === 1'b1) done_q.push_back('{wrote: evict_wrote_o, cyc: cyc});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_dirty(input logic [7:0] a, input logic v);
    pl_en = 1'b1; pl_addr = a; pl_val = v;
    tick;
    pl_en = 1'b0;
  endtask

  task automatic load_line(input logic [19:0] tag, input logic [7:0] idx, input logic [31:0] base,
                           input bit expect_beats);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] w;
      w = 2'(k);
      data_mem[{idx, w}] = base + 32'(k);
      if (expect_beats) sb.push_back('{addr: {tag, idx, w, 2'b00}, data: base + 32'(k), last: (k == 3)});
    end
  endtask

  task automatic request(input logic [7:0] idx, input logic [19:0] tag, output int unsigned rc);
    evict_i = 1'b1; evict_index_i = idx; evict_tag_i = tag;
    rc = cyc;
    tick;
    evict_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, output logic wrote, output int unsigned dc);
    for (int i = 0; i < 200; i++) begin
      if (done_q.size() > 0) break;
      tick;
    end
    chk({tag, "_done_seen"}, done_q.size() > 0, 1'b1);
    wrote = 1'bx; dc = 0;
    if (done_q.size() > 0) begin
      done_t d;
      d = done_q.pop_front();
      wrote = d.wrote; dc = d.cyc;
    end
  endtask

  initial begin
    int unsigned rc, dc, dc2, b0, w0, s0;
    logic wr;

    rst_i = 1'b1; evict_i = 1'b0; evict_index_i = '0; evict_tag_i = '0;
    mem_ready_i = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_val = 1'b0;
    repeat (3) tick;
    chk("rst_ready", evict_ready_o, 1'b1);
    chk("rst_done", evict_done_o, 1'b0);
    chk("rst_wrote", evict_wrote_o, 1'b0);
    chk("rst_strobes", {dirty_read_o, dirty_write_o, data_read_o}, 3'b000);
    chk("rst_mem", {mem_valid_o, mem_last_o}, 2'b00);
    rst_i = 1'b0;
    tick;

    // 1: clean line
    set_dirty(8'h12, 1'b0);
    b0 = beats; w0 = dwrites;
    request(8'h12, 20'h11111, rc);
    wait_done("clean", wr, dc);
    chk("clean_wrote", wr, 1'b0);
    chk("clean_latency", dc - rc + 1, 4);
    tick;
    chk("clean_beats", beats - b0, 0);
    chk("clean_dwrites", dwrites - w0, 0);
    chk("clean_ready_after", evict_ready_o, 1'b1);

    // 2: dirty line, no stalls
    set_dirty(8'h05, 1'b1);
    load_line(20'hABCDE, 8'h05, 32'h0000_00A0, 1'b1);
    b0 = beats; w0 = dwrites;
    request(8'h05, 20'hABCDE, rc);
    wait_done("dirty", wr, dc);
    chk("dirty_wrote", wr, 1'b1);
    chk("dirty_latency", dc - rc + 1, 17);
    chk("dirty_beats", beats - b0, 4);
    chk("dirty_sb_empty", sb.size(), 0);
    chk("dirty_cleared", dirty_mem[8'h05], 1'b0);
    chk("dirty_dwrites", dwrites - w0, 1);

    // 3: stall three cycles on the second beat
    set_dirty(8'h05, 1'b1);
    load_line(20'hABCDE, 8'h05, 32'h0000_00B0, 1'b1);
    b0 = beats; s0 = stall_checks;
    request(8'h05, 20'hABCDE, rc);
    for (int i = 0; i < 100; i++) begin
      if (mem_valid_o && (beats - b0 == 1)) break;
      tick;
    end
    chk("stall_beat2_valid", mem_valid_o, 1'b1);
    mem_ready_i = 1'b0;
    repeat (3) tick;
    mem_ready_i = 1'b1;
    wait_done("stall", wr, dc);
    chk("stall_wrote", wr, 1'b1);
    chk("stall_latency", dc - rc + 1, 20);
    chk("stall_cycles", stall_checks - s0, 3);
    chk("stall_sb_empty", sb.size(), 0);

    // 4: request pulsed mid-writeback is ignored
    set_dirty(8'h33, 1'b1);
    set_dirty(8'h44, 1'b1);
    load_line(20'h12345, 8'h33, 32'h0000_00C0, 1'b1);
    b0 = beats;
    request(8'h33, 20'h12345, rc);
    repeat (5) tick;
    evict_i = 1'b1; evict_index_i = 8'h44; evict_tag_i = 20'h54321;
    tick;
    evict_i = 1'b0;
    wait_done("ignore_first", wr, dc);
    chk("ignore_first_wrote", wr, 1'b1);
    chk("ignore_first_beats", beats - b0, 4);
    repeat (3) tick;
    chk("ignore_no_extra_done", done_q.size(), 0);
    chk("ignore_44_still_dirty", dirty_mem[8'h44], 1'b1);
    load_line(20'h54321, 8'h44, 32'h0000_00D0, 1'b1);
    request(8'h44, 20'h54321, rc);
    wait_done("ignore_second", wr, dc);
    chk("ignore_second_wrote", wr, 1'b1);
    chk("ignore_second_cleared", dirty_mem[8'h44], 1'b0);
    chk("ignore_sb_empty", sb.size(), 0);

    // 5: reset during the first SEND beat
    set_dirty(8'h21, 1'b1);
    load_line(20'h0F0F0, 8'h21, 32'h0000_00E0, 1'b0);
    mem_ready_i = 1'b0;
    request(8'h21, 20'h0F0F0, rc);
    for (int i = 0; i < 100; i++) begin
      if (mem_valid_o) break;
      tick;
    end
    chk("rstmid_beat1_valid", mem_valid_o, 1'b1);
    chk("rstmid_beat1_addr", mem_address_o, 32'h0F0F_0210);
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    mem_ready_i = 1'b1;
    chk("rstmid_mem", {mem_valid_o, mem_last_o}, 2'b00);
    chk("rstmid_strobes", {dirty_read_o, dirty_write_o, data_read_o}, 3'b000);
    chk("rstmid_done", {evict_done_o, evict_wrote_o}, 2'b00);
    chk("rstmid_ready", evict_ready_o, 1'b1);
    repeat (3) tick;
    chk("rstmid_still_dirty", dirty_mem[8'h21], 1'b1);
    chk("rstmid_no_done", done_q.size(), 0);

    // 6: back-to-back dirty then clean, second request held until ready
    set_dirty(8'h00, 1'b1);
    set_dirty(8'hFF, 1'b0);
    load_line(20'h00777, 8'h00, 32'h0000_00F0, 1'b1);
    b0 = beats;
    request(8'h00, 20'h00777, rc);
    evict_i = 1'b1; evict_index_i = 8'hFF; evict_tag_i = 20'h00888;
    for (int i = 0; i < 100; i++) begin
      if (evict_ready_o) break;
      tick;
    end
    chk("b2b_ready_seen", evict_ready_o, 1'b1);
    tick;
    evict_i = 1'b0;
    wait_done("b2b_first", wr, dc);
    chk("b2b_first_wrote", wr, 1'b1);
    chk("b2b_first_latency", dc - rc + 1, 17);
    wait_done("b2b_second", wr, dc2);
    chk("b2b_second_wrote", wr, 1'b0);
    chk("b2b_second_gap", dc2 - dc, 4);
    chk("b2b_beats", beats - b0, 4);
    chk("b2b_dirty00_cleared", dirty_mem[8'h00], 1'b0);
    chk("b2b_sb_empty", sb.size(), 0);

    repeat (2) tick;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
